flappy_game_engine: RTL



---
 rtl/flappy_pkg.sv | 36 +++
 rtl/flappy_pipe.sv | 82 ++++++++
 rtl/flappy_game_engine.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: state encoding, colours, screen geometry and the LFSR step helper
// shared by flappy_game_engine and flappy_pipe.
package flappy_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_DEAD = 2'd2
   } state_e;

   localparam logic [11:0] COL_BLACK  = 12'h000;
   localparam logic [11:0] COL_BIRD   = 12'hFF0;
   localparam logic [11:0] COL_PIPE   = 12'h333;
   localparam logic [11:0] COL_GROUND = 12'h999;
   localparam logic [11:0] COL_SKY    = 12'h697;

   localparam int POS_W = 11;
   // Pipe x carries one extra bit: off-screen spawn points run past 1023.
   localparam int X_W   = 12;

   localparam int Y_CEIL       = 34;
   localparam int Y_GROUND     = 514;
   localparam int SCREEN_W     = 640;
   localparam int BIRD_X       = 200;
   localparam int BIRD_HALF    = 10;
   localparam int PIPE_HALF    = 25;
   localparam int BIRD_Y_INIT  = 250;
   localparam int GAP_TOP_INIT = 200;
   localparam int GAP_TOP_MIN  = 64;

   // x^16+x^14+x^13+x^11+1 in right-shift form: feedback from bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LFSR_TAPS), s[15:1]};
   endfunction
endpackage

// File: rtl/flappy_pipe.sv
// flappy_pipe: one scrolling pipe channel - position, gap top, passed flag,
// respawn, plus collision / pass / pixel-hit decode on the current state.
module flappy_pipe
   import flappy_pkg::*;
#(
   parameter int X_INIT       = 640,
   parameter int NUM_PIPES    = 3,
   parameter int PIPE_SPACING = 240,
   parameter int PIPE_SPEED   = 3,
   parameter int GAP_H        = 160
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    restart_i,
   input  logic                    advance_i,
   input  logic                    score_en_i,
   input  logic [9:0]              respawn_top_i,
   input  logic signed [POS_W-1:0] bird_y_i,
   input  logic [9:0]              h_count_i,
   input  logic [9:0]              v_count_i,
   output logic                    overlap_o,
   output logic                    pass_o,
   output logic                    pixel_o
);
   localparam logic signed [X_W-1:0] X_RESET   = X_W'(X_INIT);
   localparam logic signed [X_W-1:0] X_SPEED   = X_W'(PIPE_SPEED);
   localparam logic signed [X_W-1:0] X_WRAP    = X_W'(NUM_PIPES * PIPE_SPACING);
   localparam logic signed [X_W-1:0] X_RESPAWN = X_W'(-PIPE_HALF);
   localparam logic signed [X_W-1:0] X_PASS    = X_W'(BIRD_X - BIRD_HALF - PIPE_HALF);
   localparam logic signed [X_W-1:0] X_HIT_HI  = X_W'(BIRD_X + BIRD_HALF + PIPE_HALF);
   localparam logic signed [X_W-1:0] X_HALF    = X_W'(PIPE_HALF);

   logic signed [X_W-1:0] x_q, x_d, x_step;
   logic [9:0]            top_q, top_d;
   logic                  passed_q, passed_d;
   logic signed [X_W-1:0] gap_lo, gap_hi, bird_top, bird_bot, h_s, v_s;

   always_comb begin
      gap_lo   = {2'b00, top_q};
      gap_hi   = {2'b00, top_q} + X_W'(GAP_H);
      bird_top = X_W'(bird_y_i) - X_W'(BIRD_HALF);
      bird_bot = X_W'(bird_y_i) + X_W'(BIRD_HALF);
      h_s      = {2'b00, h_count_i};
      v_s      = {2'b00, v_count_i};

      // Closed intervals: touching a pipe edge counts, touching the gap edge is safe.
      overlap_o = (x_q >= X_PASS) && (x_q <= X_HIT_HI) &&
                  ((bird_top < gap_lo) || (bird_bot > gap_hi));
      pass_o    = score_en_i && !passed_q && (x_q < X_PASS);
      pixel_o   = (h_s >= x_q - X_HALF) && (h_s <= x_q + X_HALF) &&
                  ((v_s < gap_lo) || (v_s > gap_hi));

      x_step   = x_q - X_SPEED;
      x_d      = x_q;
      top_d    = top_q;
      passed_d = passed_q | pass_o;
      if (restart_i) begin
         x_d      = X_RESET;
         top_d    = 10'(GAP_TOP_INIT);
         passed_d = 1'b0;
      end else if (advance_i) begin
         x_d = x_step;
         if (x_step <= X_RESPAWN) begin
            x_d      = x_step + X_WRAP;
            top_d    = respawn_top_i;
            passed_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q      <= X_RESET;
         top_q    <= 10'(GAP_TOP_INIT);
         passed_q <= 1'b0;
      end else begin
         x_q      <= x_d;
         top_q    <= top_d;
         passed_q <= passed_d;
      end
   end
endmodule

// File: rtl/flappy_game_engine.sv
// flappy_game_engine: frame-stepped Flappy Bird core (FSM, bird, LFSR, score, colour).
// Define FLAPPY_HISCORE_EN to keep a best-score register on hi_score.
module flappy_game_engine
   import flappy_pkg::*;
#(
   parameter int          NUM_PIPES    = 3,
   parameter int          SCORE_W      = 8,
   parameter int          PIPE_SPACING = 240,
   parameter int          PIPE_SPEED   = 3,
   parameter int          GAP_H        = 160,
   parameter int          GRAVITY      = 1,
   parameter int          JUMP_V       = 10,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               frame_tick,
   input  logic               up,
   input  logic               bright,
   input  logic [9:0]         hCount,
   input  logic [9:0]         vCount,
   output logic [11:0]        rgb,
   output logic [SCORE_W-1:0] score,
   output logic               game_over,
   output logic [1:0]         state_o,
   output logic [SCORE_W-1:0] hi_score
);
   localparam logic signed [POS_W-1:0] Y_INIT    = POS_W'(BIRD_Y_INIT);
   localparam logic signed [POS_W-1:0] V_JUMP    = POS_W'(-JUMP_V);
   localparam logic signed [POS_W-1:0] V_GRAV    = POS_W'(GRAVITY);
   localparam logic signed [X_W-1:0]   Y_CEIL_S  = X_W'(Y_CEIL);
   localparam logic signed [X_W-1:0]   Y_GND_S   = X_W'(Y_GROUND);
   localparam logic [SCORE_W-1:0]      SCORE_MAX = '1;

   state_e                  state_q;
   logic                    game_over_q, up_q, pending_q, up_rise;
   logic signed [POS_W-1:0] bird_y_q, vel_q;
   logic [15:0]             lfsr_q;
   logic [SCORE_W-1:0]      score_q, score_d;
   logic [11:0]             rgb_q, rgb_d;
   logic signed [X_W-1:0]   bird_top, bird_bot, v_s;
   logic                    tick_play, crash, advance, restart, bird_pix;
   logic [9:0]              respawn_top;
   logic [NUM_PIPES-1:0]    pipe_overlap, pipe_pass, pipe_pix;

   always_comb begin
      up_rise     = up & ~up_q;
      tick_play   = frame_tick && (state_q == ST_PLAY);
      bird_top    = X_W'(bird_y_q) - X_W'(BIRD_HALF);
      bird_bot    = X_W'(bird_y_q) + X_W'(BIRD_HALF);
      crash       = (|pipe_overlap) || (bird_top <= Y_CEIL_S) || (bird_bot >= Y_GND_S);
      advance     = tick_play && !crash;
      restart     = frame_tick && (state_q == ST_DEAD) && pending_q;
      respawn_top = 10'(GAP_TOP_MIN) + {2'b00, lfsr_q[7:0]};
      score_d     = score_q;
      if (tick_play && (|pipe_pass) && (score_q != SCORE_MAX))
         score_d = score_q + SCORE_W'(1);

      v_s      = {2'b00, vCount};
      bird_pix = (hCount >= 10'(BIRD_X - BIRD_HALF)) && (hCount <= 10'(BIRD_X + BIRD_HALF)) &&
                 (v_s >= bird_top) && (v_s <= bird_bot);
      if (!bright)
         rgb_d = COL_BLACK;
      else if (bird_pix)
         rgb_d = COL_BIRD;
      else if (|pipe_pix)
         rgb_d = COL_PIPE;
      else if (vCount >= 10'(Y_GROUND))
         rgb_d = COL_GROUND;
      else
         rgb_d = COL_SKY;
   end

   genvar gi;
   for (gi = 0; gi < NUM_PIPES; gi++) begin : g_pipe
      flappy_pipe #(
         .X_INIT      (SCREEN_W + gi * PIPE_SPACING),
         .NUM_PIPES   (NUM_PIPES),
         .PIPE_SPACING(PIPE_SPACING),
         .PIPE_SPEED  (PIPE_SPEED),
         .GAP_H       (GAP_H)
      ) u_pipe (
         .clk          (clk),
         .rst_n        (rst_n),
         .restart_i    (restart),
         .advance_i    (advance),
         .score_en_i   (tick_play),
         .respawn_top_i(respawn_top),
         .bird_y_i     (bird_y_q),
         .h_count_i    (hCount),
         .v_count_i    (vCount),
         .overlap_o    (pipe_overlap[gi]),
         .pass_o       (pipe_pass[gi]),
         .pixel_o      (pipe_pix[gi])
      );
   end

   // The dying tick freezes motion but still banks a pass from the same tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         game_over_q <= 1'b0;
         up_q        <= 1'b0;
         pending_q   <= 1'b0;
         bird_y_q    <= Y_INIT;
         vel_q       <= '0;
         lfsr_q      <= LFSR_SEED;
         score_q     <= '0;
         rgb_q       <= '0;
      end else begin
         up_q  <= up;
         rgb_q <= rgb_d;
         if (frame_tick)
            pending_q <= up_rise;
         else if (up_rise)
            pending_q <= 1'b1;
         if (frame_tick) begin
            unique case (state_q)
               ST_IDLE: begin
                  if (pending_q) begin
                     state_q <= ST_PLAY;
                     vel_q   <= V_JUMP;
                  end
               end
               ST_PLAY: begin
                  score_q <= score_d;
                  if (crash) begin
                     state_q     <= ST_DEAD;
                     game_over_q <= 1'b1;
                  end else begin
                     bird_y_q <= bird_y_q + vel_q;
                     vel_q    <= pending_q ? V_JUMP : vel_q + V_GRAV;
                     lfsr_q   <= lfsr_step(lfsr_q);
                  end
               end
               ST_DEAD: begin
                  if (pending_q) begin
                     state_q     <= ST_IDLE;
                     game_over_q <= 1'b0;
                     score_q     <= '0;
                     bird_y_q    <= Y_INIT;
                     vel_q       <= '0;
                  end
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef FLAPPY_HISCORE_EN
   logic [SCORE_W-1:0] hi_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         hi_q <= '0;
      else if (tick_play && crash && (score_d > hi_q))
         hi_q <= score_d;
   end
   assign hi_score = hi_q;
`else
   assign hi_score = '0;
`endif

   assign rgb       = rgb_q;
   assign score     = score_q;
   assign game_over = game_over_q;
   assign state_o   = state_q;
endmodule
